// File: rtl/dff_logic_bank_if.sv
// Signal bundle for dff_logic_bank: enable and per-channel data in, state and all-clear status out.
interface dff_logic_bank_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [N-1:0]     x;
  logic [N-1:0]     q;
  logic             z;
  logic [CNT_W-1:0] z_run;

  modport master (output en, x, input q, z, z_run);
  modport slave  (input en, x, output q, z, z_run);
endinterface

// File: rtl/dff_logic_bank.sv
// Bank of N single-bit state flops with per-channel fixed next-state modes, clock enable,
// and a saturating run counter on the all-clear flag.
module dff_logic_bank #(
  parameter int unsigned    N         = 3,
  parameter                 MODES     = 6'b10_01_00,
  parameter logic [N-1:0]   RESET_VAL = '0,
  parameter int unsigned    CNT_W     = 4
) (
  input logic              clk,
  input logic              reset,
  dff_logic_bank_if.slave  bus
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "dff_logic_bank: N must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "dff_logic_bank: CNT_W must be at least 1");
  end
  if ($bits(MODES) != 2 * N) begin : g_bad_modes
    $fatal(1, "dff_logic_bank: MODES width must equal 2*N");
  end

  localparam logic [2*N-1:0]   ModesL = MODES;
  localparam logic [CNT_W-1:0] RunMax = '1;

  logic [N-1:0]     q_q, q_d, d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             z;

  // Modes are elaboration constants, so each channel collapses to a single gate.
  for (genvar i = 0; i < N; i++) begin : g_ch
    localparam logic [1:0] Mode = ModesL[2*i +: 2];
    if (Mode == 2'd0) begin : g_toggle
      assign d[i] = bus.x[i] ^ q_q[i];
    end else if (Mode == 2'd1) begin : g_and_not
      assign d[i] = bus.x[i] & ~q_q[i];
    end else if (Mode == 2'd2) begin : g_or_not
      assign d[i] = bus.x[i] | ~q_q[i];
    end else begin : g_load
      assign d[i] = bus.x[i];
    end
  end

  assign z = ~|q_q;

  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      q_d = d;
    end
  end

  // Counter runs regardless of en so a frozen all-clear state can be timed.
  always_comb begin
    run_d = '0;
    if (z) begin
      run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      run_q <= '0;
    end else begin
      q_q   <= q_d;
      run_q <= run_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.z     = z;
  assign bus.z_run = run_q;

endmodule

// File: doc/dff_logic_bank.md
# dff_logic_bank

Parametrised successor to the fixed three-flop x/z state circuit: a bank of N single-bit state registers, each with a per-channel next-state mode. It adds synchronous reset, a clock enable, per-channel inputs and a saturating run counter on the all-clear indicator. It sits in the small-FSM/puzzle-circuit family, as the reusable replacement for hand-wired flop-plus-gate assemblies.

## Interface
- N, default 3: number of state channels, minimum 1.
- MODES, default 6'b10_01_00: 2N-bit packed per-channel mode. Channel i uses MODES[2i+1:2i].
- RESET_VAL, default all zeros: N-bit reset value of the q register.
- CNT_W, default 4: width of z_run, minimum 1.
- clk  input  1  clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- en  input  1  state-update enable.
- x  input  N  per-channel data input. Tie all bits together for broadcast use.
- q  output  N  state register contents.
- z  output  1  all-clear flag, ~|q. Combinational from registers only.
- z_run  output  CNT_W  consecutive-cycle count of z==1, saturating.

## Operation
- The next-state function d[i] for channel i, by mode:
  - Mode 0 (toggle): d = x[i] ^ q[i].
  - Mode 1 (and-not): d = x[i] & ~q[i].
  - Mode 2 (or-not): d = x[i] | ~q[i].
  - Mode 3 (load): d = x[i].
- Modes are elaboration-time constants; there is no runtime mode change.
- Register update at every rising clk edge, in priority order:
  1. If reset=1: q <= RESET_VAL and z_run <= 0.
  2. Otherwise, if en=1: q <= d for all channels simultaneously.
  3. Otherwise (en=0): q holds.
- z = NOR of all q bits. It depends on q only, never on x or en. This gives no combinational input-to-output path.
- z_run update, when not in reset, at every edge regardless of en:
  - If z=1 (pre-edge value): z_run <= z_run + 1, saturating at 2^CNT_W - 1. It holds at the maximum and never wraps.
  - If z=0: z_run <= 0.
- Channels are independent. No channel's next state depends on another channel's q.
- With N=3, default MODES, RESET_VAL=0, x broadcast and en=1, the block is cycle-identical to the first-generation circuit after reset.
- Elaboration checks: N>=1, CNT_W>=1, width of MODES == 2N. A failed check is a fatal elaboration error.

## Timing
- Latency: x and en affect q at the next rising edge. z follows q in the same cycle, combinationally.
- Reset values:
  - q = RESET_VAL.
  - z = ~|RESET_VAL (1 for the default).
  - z_run = 0.
- z_run first counts at the first non-reset edge where z=1. With default reset, z_run=1 one cycle after reset deasserts.
- Reset mid-operation takes effect at the next edge and overrides en and x. z_run clears even when saturated.
- If reset and en are both high, reset wins.
- When en=0 with z=1, z_run keeps counting because q is frozen. This is the intended way to time an idle-clear window.
- Saturation: at z_run = 2^CNT_W - 1 with z=1, the value stays put. The next z=0 cycle clears it to 0 in one edge.
- There are no multicycle paths and no handshake. Throughput is one update per enabled cycle.

## Test plan
1. Legacy, x=0 held. Setup: N=3, default params, reset for 1 cycle, then en=1 and x=3'b000. Required: q (bit2..0) sequence 000, 100, 000, 100…; z sequence 1, 0, 1, 0…; z_run sequence 0, 1, 0, 1….
2. Legacy, x=1 held. Setup: as scenario 1 but x=3'b111. Required: q sequence 000, 111, 100, 111, 100…; z sequence 1, 0, 0, 0…; z_run sequence 0, 1, 0, 0….
3. Enable hold. Setup: start from q=111; drop en for 3 cycles while toggling x. Required: q stays 111, z stays 0. Then drive en=1 with x=3'b111. Required: q=100 at the next edge.
4. Saturation. Setup: CNT_W=2, x=0, all channels in mode 1, reset, then hold. Required: z stays 1; z_run sequence 0, 1, 2, 3, 3, 3. Then pulse reset. Required: z_run=0 at the next edge.
5. Load mode with non-zero reset. Setup: N=8, MODES all 3, RESET_VAL=8'hA5. Required: q=A5 and z=0 after reset. Then drive x=8'h00. Required: q=00 and z=1 after one edge; z_run=1 after the following edge.
6. Reset versus enable collision. Setup: assert reset and en together while x=3'b111, starting from q=100. Required: q=000 and z_run=0 at the edge.
